// File: rtl/mod_result_display.sv
// mod_result_display: latch remainder/error, double-dabble to BCD, scan active-low 7-seg with "Er" on error (MOD_DISP_BLINK_EN blinks "Er")
module mod_result_display #(
  parameter int N = 4,
  parameter int DIGITS = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [N-1:0]      remainder,
  input  logic              error,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
  state_t state;
  logic [N-1:0] bin;
  logic [BW-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  logic err_q;
  logic [6:0] digit [DIGITS];
  logic [6:0] code [DIGITS];
  logic [RW-1:0] ref_cnt;
  logic [IW-1:0] idx;
  logic blank_now;
  if (N < 2 || N > 8 || REFRESH_DIV < 2 || BLINK_DIV < 1 || 10 ** DIGITS <= 2 ** N - 1) begin : g_bad_params
    $error("mod_result_display: illegal parameter combination");
  end
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && bcd[4*i +: 4] == 4'd0 && i != 0;
      code[i] = err_q ? (i == 1 ? 7'b0000110 : i == 0 ? 7'b0101111 : BLANK)
              : lead ? BLANK : seg7(bcd[4*i +: 4]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      err_q <= 1'b0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      for (int i = 0; i < DIGITS; i++) digit[i] <= BLANK;
    end else case (state)
      IDLE: if (result_valid && !busy) begin
        bin <= remainder;
        err_q <= error;
        bcd <= '0;
        cnt <= '0;
        busy <= 1'b1;
        state <= error ? LOAD : CONVERT;
      end
      CONVERT: begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(N - 1)) state <= LOAD;
      end
      LOAD: begin
        for (int i = 0; i < DIGITS; i++) digit[i] <= code[i];
        busy <= 1'b0;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx <= '0;
      seg <= BLANK;
      an <= ~DIGITS'(1);
    end else begin
      ref_cnt <= ref_cnt == RW'(REFRESH_DIV - 1) ? '0 : ref_cnt + RW'(1);
      if (ref_cnt == RW'(REFRESH_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      an <= ~(DIGITS'(1) << idx);
      seg <= blank_now ? BLANK : digit[idx];
    end
  end
`ifdef MOD_DISP_BLINK_EN
  localparam int KW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [KW-1:0] blink_cnt;
  logic blink_off, err_disp;
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
      err_disp <= 1'b0;
    end else if (state == LOAD) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
      err_disp <= err_q;
    end else if (blink_cnt == KW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else blink_cnt <= blink_cnt + KW'(1);
  end
  assign blank_now = err_disp && blink_off;
`else
  assign blank_now = 1'b0;
`endif
endmodule

// File: tb/tb_mod_result_display.sv
// tb_mod_result_display: directed and random captures checked against a decimal display model
module tb_mod_result_display;
  localparam int N = 4;
  localparam int DIGITS = 2;
  localparam int RD = 4;
  localparam int BD = 8;
  localparam logic [6:0] BL = 7'b1111111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic result_valid = 1'b0;
  logic error = 1'b0;
  logic [N-1:0] remainder = '0;
  logic busy;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;
  int tests = 0;
  int fails = 0;
  int blanks, an_bad, bc;
  logic [6:0] seen [DIGITS];
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  mod_result_display #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .remainder(remainder),
    .error(error), .busy(busy), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] expect_digit(input int v, input bit e, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    if (e) return d == 1 ? 7'b0000110 : d == 0 ? 7'b0101111 : BL;
    if (d > 0 && v < p) return BL;
    return segtab[(v / p) % 10];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle;
    while (busy && bc < 50) begin
      bc++;
      tick;
    end
  endtask
  task automatic capture(input int v, input bit e);
    remainder = N'(v);
    error = e;
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    bc = 0;
    wait_idle;
  endtask
  task automatic read_display(input int n);
    for (int d = 0; d < DIGITS; d++) seen[d] = 'x;
    blanks = 0;
    an_bad = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (seg === BL) blanks++;
      if (an === 2'b10) seen[0] = seg;
      else if (an === 2'b01) seen[1] = seg;
      else an_bad++;
    end
  endtask
  task automatic check_display(input string tag, input int v, input bit e);
    read_display(2 * RD);
    check({tag, "_an"}, an_bad, 0);
    for (int d = 0; d < DIGITS; d++)
      check($sformatf("%s_d%0d", tag, d), seen[d], expect_digit(v, e, d));
  endtask
  initial begin
    int v;
    bit e;
    tick;
    tick;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_seg", seg, BL);
    check("rst_an", an, 2'b10);
    for (int j = 1; j <= 12; j++) begin
      tick;
      check($sformatf("scan_an_%0d", j), an, ((j - 1) / RD) % 2 ? 2'b01 : 2'b10);
    end
    capture(7, 0);
    check("busy7", bc, N + 1);
    check_display("val7", 7, 0);
    capture(12, 0);
    check("busy12", bc, N + 1);
    check_display("val12", 12, 0);
    capture(0, 0);
    check_display("val0", 0, 0);
    capture(6, 1);
    check("busy_err", bc, 1);
    check_display("err_on", 0, 1);
    read_display(BD);
`ifdef MOD_DISP_BLINK_EN
    check("err_blink_blanks", blanks, BD);
`else
    check("err_steady_blanks", blanks, 0);
`endif
    check_display("err_on2", 0, 1);
    remainder = 4'd9;
    error = 1'b0;
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    tick;
    remainder = 4'd3;
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    bc = 0;
    wait_idle;
    check_display("drop9", 9, 0);
    for (int i = 0; i < 10; i++) tick;
    check("drop_busy", busy, 0);
    check_display("drop9_again", 9, 0);
    remainder = 4'd15;
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_seg", seg, BL);
    read_display(2 * RD);
    check("midrst_d0", seen[0], BL);
    check("midrst_d1", seen[1], BL);
    capture(5, 0);
    check_display("after_rst5", 5, 0);
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 15));
      e = $urandom_range(0, 3) == 0;
      capture(v, e);
      check($sformatf("rnd%0d_busy", i), bc, e ? 1 : N + 1);
      check_display($sformatf("rnd%0d_v%0d_e%0d", i, v, e), v, e);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
